// File: rtl/ps2_direction_input.sv
// PS/2 keyboard receiver that decodes arrow/WASD make codes into a registered
// 32-bit player direction (1=up, 2=right, 3=down, 4=left) for the move1 input.
`timescale 1ns/1ps
module ps2_direction_input #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned RESET_DIR      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] move,
    output logic        byte_valid,
    output logic [7:0]  last_code,
    output logic        frame_error
);
    localparam logic [2:0] RESET_MOVE = RESET_DIR[2:0];

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic        data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_ok_q, par_ok_d;
    logic [31:0] wd_q, wd_d;
    logic        ext_q, ext_d, brk_q, brk_d;
    logic [2:0]  move_q, move_d;
    logic [7:0]  last_code_q, last_code_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_error_q, frame_error_d;
    logic        fall;
    logic [2:0]  cand;

    function automatic logic [2:0] map_code(input logic ext, input logic [7:0] code);
        logic [2:0] dir;
        dir = 3'd0;
        if (ext) begin
            case (code)
                8'h75: dir = 3'd1;
                8'h74: dir = 3'd2;
                8'h72: dir = 3'd3;
                8'h6B: dir = 3'd4;
                default: dir = 3'd0;
            endcase
        end else begin
            case (code)
                8'h1D: dir = 3'd1;
                8'h23: dir = 3'd2;
                8'h1B: dir = 3'd3;
                8'h1C: dir = 3'd4;
                default: dir = 3'd0;
            endcase
        end
        return dir;
    endfunction

    function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
        return (a == 3'd1 && b == 3'd3) || (a == 3'd3 && b == 3'd1) ||
               (a == 3'd2 && b == 3'd4) || (a == 3'd4 && b == 3'd2);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_prev_q    <= 1'b1;
            data_s1_q     <= 1'b1;
            data_s2_q     <= 1'b1;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_ok_q      <= 1'b0;
            wd_q          <= 32'd0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            move_q        <= RESET_MOVE;
            last_code_q   <= 8'h00;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_ok_q      <= par_ok_d;
            wd_q          <= wd_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            move_q        <= move_d;
            last_code_q   <= last_code_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        clk_s1_d      = ps2_clk;
        clk_s2_d      = clk_s1_q;
        clk_prev_d    = clk_s2_q;
        data_s1_d     = ps2_data;
        data_s2_d     = data_s1_q;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_ok_d      = par_ok_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        move_d        = move_q;
        last_code_d   = last_code_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        cand          = 3'd0;
        fall          = clk_prev_q & ~clk_s2_q;

        if (state_q == S_IDLE || fall)
            wd_d = 32'd0;
        else if (wd_q < TIMEOUT_CYCLES)
            wd_d = wd_q + 32'd1;
        else
            wd_d = wd_q;

        // A real edge wins over an expiring watchdog in the same cycle.
        if (state_q != S_IDLE && !fall && wd_q >= TIMEOUT_CYCLES) begin
            state_d       = S_IDLE;
            frame_error_d = 1'b1;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
            wd_d          = 32'd0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_d = ^{shift_q, data_s2_q};
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (data_s2_q && par_ok_q) begin
                        byte_valid_d = 1'b1;
                        last_code_d  = shift_q;
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (!brk_q)
                                cand = map_code(ext_q, shift_q);
                            if (cand != 3'd0 && !is_opposite(cand, move_q))
                                move_d = cand;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        ext_d         = 1'b0;
                        brk_d         = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign move        = {29'd0, move_q};
    assign byte_valid  = byte_valid_q;
    assign last_code   = last_code_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_ps2_direction_input.sv
// Bench for ps2_direction_input: directed key sequences plus random frames,
// checked against a byte-level model of the keyboard-to-direction rules.
`timescale 1ns/1ps
module tb_ps2_direction_input;
    localparam int TO   = 200;
    localparam int HALF = 80;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] move;
    logic        byte_valid;
    logic [7:0]  last_code;
    logic        frame_error;

    ps2_direction_input #(.TIMEOUT_CYCLES(TO), .RESET_DIR(2)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .move(move), .byte_valid(byte_valid), .last_code(last_code),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int bv_cnt = 0, fe_cnt = 0, overlap_cnt = 0, unstable_cnt = 0;
    logic [31:0] move_prev = 32'd2;

    int       m_move = 2;
    bit       m_ext = 0, m_brk = 0;
    bit [7:0] m_last = 8'h00;
    int       m_bv = 0, m_fe = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (byte_valid) bv_cnt++;
        if (frame_error) fe_cnt++;
        if (byte_valid && frame_error) overlap_cnt++;
        if (!reset && move !== move_prev && !byte_valid) unstable_cnt++;
        move_prev = move;
    end

    // Keyboard rules at byte granularity: prefixes, releases, direction map, no reversal.
    task automatic model_byte(input bit [7:0] b, input bit good);
        int cand;
        bit [7:0] keys [8] = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75, 8'h74, 8'h72, 8'h6B};
        if (!good) begin
            m_fe++;
            m_ext = 0; m_brk = 0;
            return;
        end
        m_bv++;
        m_last = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            cand = 0;
            if (!m_brk)
                for (int i = 0; i < 4; i++)
                    if (keys[i + (m_ext ? 4 : 0)] == b) cand = i + 1;
            if (cand != 0 && cand != ((m_move + 1) % 4) + 1) m_move = cand;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input bit v);
        ps2_data = v;
        #(HALF) ps2_clk = 1'b0;
        #(HALF) ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input bit [7:0] b, input bit bad_par, input string tag);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        #(HALF);
        @(negedge clock);
        model_byte(b, !bad_par);
        check({tag, "_move"}, move, m_move);
        check({tag, "_last"}, last_code, m_last);
        check({tag, "_bv"}, bv_cnt, m_bv);
        check({tag, "_fe"}, fe_cnt, m_fe);
    endtask

    task automatic send_partial(input bit [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    initial begin
        bit [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
                                8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h29, 8'hE0};
        bit [7:0] rb;
        repeat (4) @(negedge clock);
        check("rst_move", move, 32'd2);
        check("rst_bv", {31'd0, byte_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_error}, 32'd0);
        check("rst_last", {24'd0, last_code}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        send_frame(8'hE0, 0, "e0a");
        send_frame(8'h74, 0, "right");
        check("plan_right", move, 32'd2);
        check("plan_right_last", {24'd0, last_code}, 32'h74);
        send_frame(8'hE0, 0, "e0b");
        send_frame(8'h75, 0, "up");
        check("plan_up", move, 32'd1);
        send_frame(8'hE0, 0, "e0c");
        send_frame(8'h72, 0, "down_rev");
        check("plan_reversal", move, 32'd1);
        send_frame(8'h1C, 0, "a_left");
        check("plan_left", move, 32'd4);
        send_frame(8'hF0, 0, "brk");
        send_frame(8'h1D, 0, "w_rel");
        check("plan_release", move, 32'd4);
        send_frame(8'h1B, 0, "s_down");
        check("plan_down", move, 32'd3);
        send_frame(8'h1D, 1, "bad_par");
        check("plan_parity_move", move, 32'd3);
        send_frame(8'h23, 0, "d_right");
        check("plan_d_right", move, 32'd2);
        send_frame(8'hE0, 0, "e0d");
        send_frame(8'h75, 0, "up2");

        send_partial(8'h5A, 4);
        ps2_data = 1'b1;
        repeat (TO + 40) @(negedge clock);
        model_byte(8'h00, 0);
        check("timeout_fe", fe_cnt, m_fe);
        check("timeout_bv", bv_cnt, m_bv);
        send_frame(8'hE0, 0, "e0e");
        send_frame(8'h6B, 0, "left_ext");
        check("plan_after_timeout", move, 32'd4);

        send_partial(8'h1D, 5);
        ps2_data = 1'b1;
        #(HALF / 2);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        m_move = 2; m_ext = 0; m_brk = 0; m_last = 8'h00;
        check("midrst_move", move, 32'd2);
        check("midrst_last", {24'd0, last_code}, 32'd0);
        reset = 1'b0;
        repeat (2 * HALF / 10) @(negedge clock);
        check("midrst_bv", bv_cnt, m_bv);
        check("midrst_fe", fe_cnt, m_fe);
        send_frame(8'h1D, 0, "after_rst");
        check("plan_after_rst", move, 32'd1);

        for (int n = 0; n < 40; n++) begin
            rb = pool[$urandom_range(11)];
            if (rb == 8'h29) rb = 8'($urandom);
            send_frame(rb, $urandom_range(7) == 0, "rnd");
        end

        check("no_overlap", overlap_cnt, 32'd0);
        check("move_stable", unstable_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end
endmodule
